// File: rtl/sram_pkg.sv
// Shared definitions for the banked SRAM: region field width, width helpers,
// default geometry and the write-slot source encoding.
package sram_pkg;

  // Width of the address region field compared against BASE.
  localparam int REGION_W = 4;

  // Default geometry used by banked_sram.
  localparam int DEF_NBANKS   = 2;
  localparam int DEF_WQ_DEPTH = 4;

  // Ceiling log2. Returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Bank-index register width. Never 0, so a single-bank build still has a
  // (constant-zero) index.
  function automatic int bank_idx_w(input int nbanks);
    return (clog2(nbanks) > 0) ? clog2(nbanks) : 1;
  endfunction

  // Queue pointer width. The depth is a power of two, so the pointers wrap
  // naturally.
  function automatic int wq_ptr_w(input int depth);
    return clog2(depth);
  endfunction

  // Which source owns the single memory write slot this cycle.
  typedef enum logic [1:0] {
    WSRC_NONE,
    WSRC_DBG,
    WSRC_QUEUE,
    WSRC_CPU
  } wsrc_e;

endpackage

// File: rtl/sram_bank.sv
// One SRAM bank with a synchronous write port and a registered read port.
// Define uselatticeprim to map the bank onto SB_RAM256x16. That mapping is
// only valid for AW=8 and DW=16.
module sram_bank #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i
);

`ifdef uselatticeprim
  SB_RAM256x16 u_ram (
    .RDATA (rdata_o),
    .RADDR (raddr_i),
    .RCLK  (clk),
    .RCLKE (re_i),
    .RE    (re_i),
    .WADDR (waddr_i),
    .WCLK  (clk),
    .WCLKE (we_i),
    .WDATA (wdata_i),
    .WE    (we_i),
    .MASK  (16'h0000)
  );
`else
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  // Write and registered read. A read of the word being written returns the old data.
  // NOTE: the array and its read register have no reset, so they map onto RAM
  // blocks; the contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/banked_sram.sv
// NBANKS-bank SRAM with one CPU read port, a CPU write port backed by a FIFO
// write queue, and a debug write port that has absolute priority.
// Define SRAM_WQ_FWD_EN to let reads proceed while the queue holds writes.
// Such reads return the newest matching queued data.
module banked_sram
  import sram_pkg::*;
#(
  parameter int         AWIDTH   = 16,
  parameter int         DWIDTH   = 16,
  parameter int         BANK_AW  = 8,
  parameter int         NBANKS   = DEF_NBANKS,
  parameter logic [3:0] BASE     = 4'h0,
  parameter int         WQ_DEPTH = DEF_WQ_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [AWIDTH-1:0]           cpu_raddr,
  input  logic                        cpu_re,
  output logic                        cpu_rready,
  output logic [DWIDTH-1:0]           cpu_rdata,
  output logic                        cpu_rvalid,
  input  logic [AWIDTH-1:0]           cpu_waddr,
  input  logic [DWIDTH-1:0]           cpu_wdata,
  input  logic                        cpu_we,
  output logic                        cpu_wready,
  input  logic [AWIDTH-1:0]           dbg_waddr,
  input  logic [DWIDTH-1:0]           dbg_wdata,
  input  logic                        dbg_we,
  output logic [wq_ptr_w(WQ_DEPTH):0] wq_count
);

  localparam int BIW    = bank_idx_w(NBANKS);
  localparam int WIDX_W = BANK_AW + clog2(NBANKS);  // bank + local word bits
  localparam int PW     = wq_ptr_w(WQ_DEPTH);
  localparam int CW     = PW + 1;

  function automatic logic is_hit(input logic [AWIDTH-1:0] a);
    return a[AWIDTH-1 -: REGION_W] == BASE;
  endfunction

  // Address bits between the word index and the region field alias onto the
  // same word. They feed no logic.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_raddr, cpu_waddr, dbg_waddr};

  // ---------------- write queue ----------------
  logic [WIDX_W-1:0] wq_widx_q [WQ_DEPTH];
  logic [DWIDTH-1:0] wq_data_q [WQ_DEPTH];
  logic [PW-1:0]     wq_wr_ptr_q, wq_rd_ptr_q;
  logic [CW-1:0]     wq_count_q;
  logic              wq_empty, push, pop;

  logic        dbg_hit, cpu_whit;
  wsrc_e       wsrc;
  logic        mem_we;
  logic [WIDX_W-1:0] mem_widx;
  logic [DWIDTH-1:0] mem_wdata;
  logic [BIW-1:0]    mem_bank;

  assign wq_empty   = (wq_count_q == '0);
  assign cpu_wready = (wq_count_q < CW'(WQ_DEPTH));
  assign wq_count   = wq_count_q;
  assign dbg_hit    = dbg_we & is_hit(dbg_waddr);
  assign cpu_whit   = cpu_we & cpu_wready & is_hit(cpu_waddr);

  // Choose the owner of the single write slot: debug, then queue head, then a direct CPU write.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wsrc = WSRC_NONE;
    if (dbg_hit)        wsrc = WSRC_DBG;
    else if (!wq_empty) wsrc = WSRC_QUEUE;
    else if (cpu_whit)  wsrc = WSRC_CPU;
  end

  assign pop  = (wsrc == WSRC_QUEUE);
  assign push = cpu_whit & (wsrc != WSRC_CPU);

  // Steer the selected source onto the shared memory write bus.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = wq_widx_q[wq_rd_ptr_q];
    mem_wdata = wq_data_q[wq_rd_ptr_q];
    case (wsrc)
      WSRC_DBG: begin
        mem_we    = 1'b1;
        mem_widx  = dbg_waddr[WIDX_W-1:0];
        mem_wdata = dbg_wdata;
      end
      WSRC_QUEUE: mem_we = 1'b1;
      WSRC_CPU: begin
        mem_we    = 1'b1;
        mem_widx  = cpu_waddr[WIDX_W-1:0];
        mem_wdata = cpu_wdata;
      end
      default: mem_we = 1'b0;
    endcase
  end

  assign mem_bank = BIW'(mem_widx >> BANK_AW);

  // Queue pointers and occupancy. A reset discards any queued writes.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs from before the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wq_wr_ptr_q <= '0;
      wq_rd_ptr_q <= '0;
      wq_count_q  <= '0;
    end else begin
      if (push) wq_wr_ptr_q <= wq_wr_ptr_q + PW'(1);
      if (pop)  wq_rd_ptr_q <= wq_rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   wq_count_q <= wq_count_q + CW'(1);
        2'b01:   wq_count_q <= wq_count_q - CW'(1);
        default: wq_count_q <= wq_count_q;
      endcase
    end
  end

  // Queue payload storage. It is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      wq_widx_q[wq_wr_ptr_q] <= cpu_waddr[WIDX_W-1:0];
      wq_data_q[wq_wr_ptr_q] <= cpu_wdata;
    end
  end

  // ---------------- read path ----------------
  logic              rd_acc, rd_hit;
  logic [WIDX_W-1:0] rd_widx;
  logic [BIW-1:0]    rd_bank;
  logic              rvalid_q, rhit_q;
  logic [BIW-1:0]    rbank_q;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic [DWIDTH-1:0] bank_rdata [NBANKS];

`ifdef SRAM_WQ_FWD_EN
  assign cpu_rready = 1'b1;
`else
  assign cpu_rready = wq_empty;
`endif

  assign rd_acc  = cpu_re & cpu_rready;
  assign rd_hit  = rd_acc & is_hit(cpu_raddr);
  assign rd_widx = cpu_raddr[WIDX_W-1:0];
  assign rd_bank = BIW'(rd_widx >> BANK_AW);

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    sram_bank #(.AW(BANK_AW), .DW(DWIDTH)) u_bank (
      .clk     (clk),
      .re_i    (rd_hit && (rd_bank == BIW'(b))),
      .raddr_i (rd_widx[BANK_AW-1:0]),
      .rdata_o (bank_rdata[b]),
      .we_i    (mem_we && (mem_bank == BIW'(b))),
      .waddr_i (mem_widx[BANK_AW-1:0]),
      .wdata_i (mem_wdata)
    );
  end

`ifdef SRAM_WQ_FWD_EN
  logic              fwd_hit;
  logic [DWIDTH-1:0] fwd_data;
  logic              rfwd_q;
  logic [DWIDTH-1:0] rfwd_data_q;

  // Scan live queue entries from oldest to newest. The last match is the newest write.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      if ((CW'(i) < wq_count_q) &&
          (wq_widx_q[wq_rd_ptr_q + PW'(i)] == rd_widx)) begin
        fwd_hit  = 1'b1;
        fwd_data = wq_data_q[wq_rd_ptr_q + PW'(i)];
      end
    end
  end

  // Register the forward decision along with the read it belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rfwd_q      <= 1'b0;
      rfwd_data_q <= '0;
    end else if (rd_acc) begin
      rfwd_q      <= rd_hit & fwd_hit;
      rfwd_data_q <= fwd_data;
    end
  end
`endif

  // Return data: a hit reads the registered bank, a miss returns zero, and the value is held between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (rvalid_q) begin
      if (!rhit_q) rdata_d = '0;
      else         rdata_d = bank_rdata[rbank_q];
`ifdef SRAM_WQ_FWD_EN
      if (rhit_q && rfwd_q) rdata_d = rfwd_data_q;
`endif
    end
  end

  // Read handshake state: a one-cycle valid pulse, the hit and bank of the accepted read, and the held data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= 1'b0;
      rhit_q   <= 1'b0;
      rbank_q  <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_acc;
      rdata_q  <= rdata_d;
      if (rd_acc) begin
        rhit_q  <= rd_hit;
        rbank_q <= rd_bank;
      end
    end
  end

  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_d;

endmodule

// File: tb/tb_banked_sram.sv
// Self-checking bench for banked_sram in its default geometry: 2 banks of
// 256x16, BASE=0, 4-entry queue. A word- and queue-level reference model
// predicts every handshake, occupancy and read result. It follows
// SRAM_WQ_FWD_EN in the same way the design does.
module tb_banked_sram;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_raddr, cpu_waddr, dbg_waddr;
  logic [15:0] cpu_wdata, dbg_wdata;
  logic        cpu_re, cpu_we, dbg_we;
  logic        cpu_rready, cpu_rvalid, cpu_wready;
  logic [15:0] cpu_rdata;
  logic [2:0]  wq_count;

  banked_sram dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_raddr  (cpu_raddr),
    .cpu_re     (cpu_re),
    .cpu_rready (cpu_rready),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_waddr  (cpu_waddr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_wready (cpu_wready),
    .dbg_waddr  (dbg_waddr),
    .dbg_wdata  (dbg_wdata),
    .dbg_we     (dbg_we),
    .wq_count   (wq_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [8:0]  w;
    logic [15:0] d;
  } wr_t;

  logic [15:0] mem_m   [512];
  bit          known_m [512];
  wr_t         q_m [$];
  logic [15:0] exp_rdata;
  bit          exp_known;

  function automatic bit is_hit(input logic [15:0] a);
    return a[15:12] == 4'h0;
  endfunction

  task automatic idle();
    cpu_re = 1'b0; cpu_we = 1'b0; dbg_we = 1'b0;
    cpu_raddr = '0; cpu_waddr = '0; cpu_wdata = '0;
    dbg_waddr = '0; dbg_wdata = '0;
  endtask

  // Check the handshakes for the current inputs, advance the model by one clock,
  // then check the registered outputs after the edge.
  task automatic cycle();
    bit          wr_ok, rd_ok, rd_known, direct;
    logic [15:0] rd_val;
    logic [8:0]  w;
    wr_t         e;
    int          n;
    n = q_m.size();
    check("wready", 32'(cpu_wready), 32'(n < 4));
`ifdef SRAM_WQ_FWD_EN
    check("rready", 32'(cpu_rready), 32'd1);
    rd_ok = cpu_re;
`else
    check("rready", 32'(cpu_rready), 32'(n == 0));
    rd_ok = cpu_re && (n == 0);
`endif
    wr_ok = cpu_we && (n < 4);
    // The read sees memory as it stood before this cycle's write.
    rd_val   = '0;
    rd_known = 1'b1;
    if (rd_ok && is_hit(cpu_raddr)) begin
      w        = cpu_raddr[8:0];
      rd_val   = mem_m[w];
      rd_known = known_m[w];
`ifdef SRAM_WQ_FWD_EN
      for (int i = n - 1; i >= 0; i--) begin
        if (q_m[i].w == w) begin
          rd_val   = q_m[i].d;
          rd_known = 1'b1;
          break;
        end
      end
`endif
    end
    direct = 1'b0;
    if (dbg_we && is_hit(dbg_waddr)) begin
      w = dbg_waddr[8:0]; mem_m[w] = dbg_wdata; known_m[w] = 1'b1;
    end else if (n > 0) begin
      e = q_m.pop_front(); mem_m[e.w] = e.d; known_m[e.w] = 1'b1;
    end else if (wr_ok && is_hit(cpu_waddr)) begin
      w = cpu_waddr[8:0]; mem_m[w] = cpu_wdata; known_m[w] = 1'b1; direct = 1'b1;
    end
    if (wr_ok && is_hit(cpu_waddr) && !direct)
      q_m.push_back('{w: cpu_waddr[8:0], d: cpu_wdata});
    @(posedge clk);
    @(negedge clk);
    if (rd_ok) begin
      exp_rdata = rd_val;
      exp_known = rd_known;
    end
    check("rvalid", 32'(cpu_rvalid), 32'(rd_ok));
    check("wq_count", 32'(wq_count), 32'(q_m.size()));
    if (exp_known) check("rdata", 32'(cpu_rdata), 32'(exp_rdata));
  endtask

  // Hold a read request until the design accepts it, within a cycle budget.
  task automatic do_read(input logic [15:0] addr);
    bit acc;
    acc = 1'b0;
    cpu_re = 1'b1; cpu_raddr = addr;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = cpu_rready;
      cycle();
    end
    cpu_re = 1'b0;
    if (!acc) check("read_timeout", 32'd0, 32'd1);
  endtask

  // Run idle cycles until the queue is empty, within a cycle budget.
  task automatic drain();
    for (int i = 0; i < 20 && q_m.size() != 0; i++) cycle();
    check("drain_empty", 32'(wq_count), 32'd0);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5, 6:
        return {7'd0, 1'($urandom_range(0, 1)), 4'd0, 4'($urandom_range(0, 15))};
      7:       return 16'h0200 | 16'($urandom_range(0, 15));
      8:       return 16'h8000 | 16'($urandom_range(0, 15));
      default: return 16'hF000 | 16'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    int k;
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    exp_rdata = '0;
    exp_known = 1'b1;
    check("rst_count",  32'(wq_count),   32'd0);
    check("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_rdata",  32'(cpu_rdata),  32'd0);
    check("rst_wready", 32'(cpu_wready), 32'd1);

    // A CPU write to an empty queue is written directly.
    cpu_we = 1'b1; cpu_waddr = 16'h0005; cpu_wdata = 16'h1234;
    cycle();
    check("t1_count", 32'(wq_count), 32'd0);
    idle();
    do_read(16'h0005);
    check("t1_rdata", 32'(cpu_rdata), 32'h1234);

    // A debug write wins the slot, and the colliding CPU write is queued.
    dbg_we = 1'b1; dbg_waddr = 16'h0010; dbg_wdata = 16'hAAAA;
    cpu_we = 1'b1; cpu_waddr = 16'h0011; cpu_wdata = 16'h5555;
    cycle();
    check("t2_count_q", 32'(wq_count), 32'd1);
    idle();
    cycle();
    check("t2_count_drain", 32'(wq_count), 32'd0);
    do_read(16'h0010);
    check("t2_dbg_data", 32'(cpu_rdata), 32'hAAAA);
    do_read(16'h0011);
    check("t2_cpu_data", 32'(cpu_rdata), 32'h5555);

    // Read-first: a direct write and a read of the same word in one cycle.
    cpu_we = 1'b1; cpu_waddr = 16'h0007; cpu_wdata = 16'h1111;
    cycle();
    cpu_wdata = 16'h2222; cpu_re = 1'b1; cpu_raddr = 16'h0007;
    cycle();
    check("rf_old_data", 32'(cpu_rdata), 32'h1111);
    idle();
    do_read(16'h0007);
    check("rf_new_data", 32'(cpu_rdata), 32'h2222);

    // The queue fills under debug pressure, and no CPU write is lost.
    k = 0;
    for (int c = 0; c < 6; c++) begin
      bit acc;
      dbg_we = 1'b1; dbg_waddr = 16'h0020 + 16'(c); dbg_wdata = 16'hD000 + 16'(c);
      cpu_we = 1'b1; cpu_waddr = 16'h0100 + 16'(k); cpu_wdata = 16'hC000 + 16'(k);
      acc = cpu_wready;
      cycle();
      if (acc) k++;
    end
    check("t3_accepted", 32'(k), 32'd4);
    check("t3_full_wready", 32'(cpu_wready), 32'd0);
    dbg_we = 1'b0;
    for (int c = 0; c < 20 && k < 6; c++) begin
      bit acc;
      cpu_we = 1'b1; cpu_waddr = 16'h0100 + 16'(k); cpu_wdata = 16'hC000 + 16'(k);
      acc = cpu_wready;
      cycle();
      if (acc) k++;
    end
    check("t3_all_accepted", 32'(k), 32'd6);
    idle();
    drain();
    for (int i = 0; i < 6; i++) begin
      do_read(16'h0100 + 16'(i));
      check("t3_readback", 32'(cpu_rdata), 32'hC000 + 32'(i));
    end

    // A read miss returns zero, and a debug write outside the region is ignored.
    do_read(16'h8005);
    check("t4_miss_rvalid", 32'(cpu_rvalid), 32'd1);
    check("t4_miss_rdata",  32'(cpu_rdata),  32'd0);
    dbg_we = 1'b1; dbg_waddr = 16'h0000; dbg_wdata = 16'h7777;
    cycle();
    dbg_waddr = 16'hF000; dbg_wdata = 16'hDEAD;
    cycle();
    idle();
    do_read(16'h0000);
    check("t4_dbg_miss", 32'(cpu_rdata), 32'h7777);

    // A read of a word that is still waiting in the queue.
    dbg_we = 1'b1; dbg_waddr = 16'h0030; dbg_wdata = 16'h3030;
    cpu_we = 1'b1; cpu_waddr = 16'h0011; cpu_wdata = 16'h6666;
    cycle();
    cpu_we = 1'b0;
    dbg_waddr = 16'h0031; cpu_re = 1'b1; cpu_raddr = 16'h0011;
`ifdef SRAM_WQ_FWD_EN
    check("t5_rready", 32'(cpu_rready), 32'd1);
    cycle();
    check("t5_fwd_data", 32'(cpu_rdata), 32'h6666);
`else
    check("t5_rready", 32'(cpu_rready), 32'd0);
    cycle();
`endif
    idle();
    do_read(16'h0011);
    check("t5_data", 32'(cpu_rdata), 32'h6666);

    // A reset discards queued writes, and memory keeps its prior contents.
    for (int i = 0; i < 3; i++) begin
      dbg_we = 1'b1; dbg_waddr = 16'h0040 + 16'(i); dbg_wdata = 16'h4000 + 16'(i);
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      dbg_we = 1'b1; dbg_waddr = 16'h0050 + 16'(i); dbg_wdata = 16'h5000 + 16'(i);
      cpu_we = 1'b1; cpu_waddr = 16'h0040 + 16'(i); cpu_wdata = 16'hBEE0 + 16'(i);
      cycle();
    end
    check("t6_count3", 32'(wq_count), 32'd3);
    idle();
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_count",  32'(wq_count),   32'd0);
    check("t6_rst_rvalid", 32'(cpu_rvalid), 32'd0);
    check("t6_rst_wready", 32'(cpu_wready), 32'd1);
    check("t6_rst_rdata",  32'(cpu_rdata),  32'd0);
    q_m.delete();
    exp_rdata = '0;
    exp_known = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_read(16'h0040 + 16'(i));
      check("t6_kept", 32'(cpu_rdata), 32'h4000 + 32'(i));
    end

    // Random traffic checked against the model.
    for (int c = 0; c < 400; c++) begin
      cpu_we    = ($urandom_range(0, 1) == 1);
      cpu_waddr = rand_addr();
      cpu_wdata = 16'($urandom());
      dbg_we    = ($urandom_range(0, 3) == 0);
      dbg_waddr = rand_addr();
      dbg_wdata = 16'($urandom());
      cpu_re    = ($urandom_range(0, 1) == 1);
      cpu_raddr = rand_addr();
      cycle();
    end
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
